bcd_digit_entry: RTL

- Sequential keypad-entry stage that accumulates decimal keystrokes into six packed BCD digit registers.
- Its digit outputs drive the BCD-to-binary converter directly downstream, which yields the 20-bit rs2 operand for the processor peripheral path.
- Provides edit keys (backspace, clear), an enter-commit, and a valid/ready handshake so the consumer samples a stable number.

---
 rtl/bcd_entry_pkg.sv | 21 ++
 rtl/bcd_shift_reg.sv | 32 +++
 rtl/bcd_digit_entry.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bcd_entry_pkg.sv
// Shared key codes, FSM state encoding and digit type for the BCD keypad-entry block.
package bcd_entry_pkg;

  localparam logic [3:0] KEY_BKSP = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hB;
  localparam logic [3:0] KEY_ENT  = 4'hC;
  localparam logic [3:0] KEY_SIGN = 4'hD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } entry_state_t;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic is_digit_key(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_shift_reg.sv
// Six-digit bidirectional BCD shift register: shift-up loads a new units digit,
// shift-down drops the units digit and fills the top with 0; clear has priority.
module bcd_shift_reg
  import bcd_entry_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                i_clr,
  input  logic                i_shift_up,
  input  logic                i_shift_down,
  input  bcd_digit_t          i_digit,
  output bcd_digit_t [5:0]    o_digits
);

  bcd_digit_t [5:0] r_digits;

  // NOTE: non-blocking assignments so every digit takes its neighbour's pre-edge value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_digits <= '0;
    end else if (i_clr) begin
      r_digits <= '0;
    end else if (i_shift_up) begin
      r_digits <= {r_digits[4:0], i_digit};
    end else if (i_shift_down) begin
      r_digits <= {4'h0, r_digits[5:1]};
    end
  end

  assign o_digits = r_digits;

endmodule

// File: rtl/bcd_digit_entry.sv
// Keypad entry stage: collects up to MAX_DIGITS decimal keys into packed BCD digits,
// with backspace/clear/enter and a valid/ready commit. Optional sign key: BCD_ENTRY_SIGN_EN.
module bcd_digit_entry
  import bcd_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 6
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  output logic [3:0] cien_millar_o,
  output logic [3:0] diez_millar_o,
  output logic [3:0] millar_o,
  output logic [3:0] centena_o,
  output logic [3:0] decena_o,
  output logic [3:0] unidad_o,
  output logic [2:0] count_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       overflow_o
`ifdef BCD_ENTRY_SIGN_EN
  ,
  output logic       neg_o
`endif
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  entry_state_t     r_state;
  entry_state_t     w_state_next;
  logic [2:0]       r_count;
  logic [2:0]       w_count_next;
  logic             r_valid;
  logic             r_overflow;
  logic             w_overflow_next;
  logic             w_sr_clr;
  logic             w_sr_up;
  logic             w_sr_down;
  logic             r_neg;
  logic             w_neg_next;
  bcd_digit_t [5:0] w_digits;

  bcd_shift_reg u_shift_reg (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .i_clr        (w_sr_clr),
    .i_shift_up   (w_sr_up),
    .i_shift_down (w_sr_down),
    .i_digit      (key_code_i),
    .o_digits     (w_digits)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_valid    <= (w_state_next == HOLD);
      r_overflow <= w_overflow_next;
      r_neg      <= w_neg_next;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_overflow_next = 1'b0;
    w_sr_clr        = 1'b0;
    w_sr_up         = 1'b0;
    w_sr_down       = 1'b0;
    w_neg_next      = r_neg;

    unique case (r_state)
      IDLE, ENTRY: begin
        if (key_valid_i) begin
          if (is_digit_key(key_code_i)) begin
            if (r_count == MAX_CNT) begin
              w_overflow_next = 1'b1;
            end else if (!(key_code_i == 4'd0 && r_count == 3'd0)) begin
              w_sr_up      = 1'b1;
              w_count_next = r_count + 3'd1;
              w_state_next = ENTRY;
            end
          end else if (key_code_i == KEY_BKSP) begin
            if (r_state == ENTRY) begin
              w_sr_down    = 1'b1;
              w_count_next = r_count - 3'd1;
              if (r_count == 3'd1) w_state_next = IDLE;
            end
          end else if (key_code_i == KEY_CLR) begin
            w_sr_clr     = 1'b1;
            w_count_next = '0;
            w_neg_next   = 1'b0;
            w_state_next = IDLE;
          end else if (key_code_i == KEY_ENT) begin
            w_state_next = HOLD;
          end
`ifdef BCD_ENTRY_SIGN_EN
          else if (key_code_i == KEY_SIGN) begin
            w_neg_next = ~r_neg;
          end
`endif
        end
      end
      HOLD: begin
        // Handshake and clear both release the value; other keys are dropped.
        if (ready_i || (key_valid_i && key_code_i == KEY_CLR)) begin
          w_sr_clr     = 1'b1;
          w_count_next = '0;
          w_neg_next   = 1'b0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_sr_clr     = 1'b1;
        w_count_next = '0;
        w_neg_next   = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  assign cien_millar_o = w_digits[5];
  assign diez_millar_o = w_digits[4];
  assign millar_o      = w_digits[3];
  assign centena_o     = w_digits[2];
  assign decena_o      = w_digits[1];
  assign unidad_o      = w_digits[0];
  assign count_o       = r_count;
  assign valid_o       = r_valid;
  assign overflow_o    = r_overflow;
`ifdef BCD_ENTRY_SIGN_EN
  assign neg_o         = r_neg;
`else
  logic w_neg_unused;
  assign w_neg_unused  = r_neg;
`endif

endmodule
